// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the fetch PC, issues one read at a time to
// instruction memory, and buffers returned words toward decode.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_mem_req,
  output logic [31:0] o_mem_adr,
  output logic        o_mem_load,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_done,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_if_valid,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_if_pc,
  input  logic        i_if_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {S_FETCH, S_DROP} state_t;

  state_t            r_state, w_next;
  logic [31:0]       r_fetch_pc, r_stale_pc;
  logic [31:0]       r_fifo_pc    [FIFO_DEPTH];
  logic [31:0]       r_fifo_instr [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_req, w_done, w_push, w_pop, w_abandon;
  logic [31:0]       w_adr;
  logic              w_unused;

  assign w_unused = ^i_redirect_pc[1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: if (w_abandon)  w_next = S_DROP;
      S_DROP:  if (i_mem_done) w_next = S_FETCH;
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_req = 1'b0;
    w_adr = r_fetch_pc;
    case (r_state)
      S_FETCH: w_req = (r_count < DEPTH_C);
      S_DROP: begin
        w_req = 1'b1;
        w_adr = r_stale_pc;
      end
      default: w_req = 1'b0;
    endcase
  end

  // A redirect that lands mid-transaction must keep the old address on the bus
  // until memory completes it, so the abandoned request is tracked separately.
  assign w_abandon = (r_state == S_FETCH) && i_redirect && w_req && !i_mem_done;
  assign w_done    = w_req && i_mem_done;
  assign w_push    = (r_state == S_FETCH) && w_done && !i_redirect;
  assign w_pop     = o_if_valid && i_if_ready && !i_redirect;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fetch_pc <= {RESET_PC[31:2], 2'b00};
      r_stale_pc <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_pc[i]    <= '0;
        r_fifo_instr[i] <= '0;
      end
    end else if (i_redirect) begin
      r_fetch_pc <= {i_redirect_pc[31:2], 2'b00};
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      if (w_abandon) r_stale_pc <= r_fetch_pc;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_wptr]    <= r_fetch_pc;
        r_fifo_instr[r_wptr] <= i_mem_rdata;
        r_wptr               <= r_wptr + PTR_W'(1);
        r_fetch_pc           <= r_fetch_pc + 32'd4;
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_mem_req   = w_req && !i_rst;
  assign o_mem_adr   = w_adr;
  assign o_mem_load  = 1'b0;
  assign o_mem_wdata = 32'h0;
  assign o_if_valid  = (r_count != '0);
  assign o_if_instr  = r_fifo_instr[r_rptr];
  assign o_if_pc     = r_fifo_pc[r_rptr];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// run compared against an expected-PC-stream model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, mem_load, mem_done;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;
  logic        redirect, if_valid, if_ready;
  logic [31:0] redirect_pc, if_instr, if_pc;

  logic        d2_req, d2_load, d2_valid;
  logic [31:0] d2_adr, d2_wdata, d2_rdata, d2_instr, d2_pc;

  int checks = 0;
  int errors = 0;
  int lat = 0;
  bit lat_rand = 1'b0;
  bit busy = 1'b0;
  int wcnt = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .o_mem_req(mem_req), .o_mem_adr(mem_adr), .o_mem_load(mem_load),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_done(mem_done),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_if_valid(if_valid), .o_if_instr(if_instr), .o_if_pc(if_pc),
    .i_if_ready(if_ready)
  );

  // Second instance exercises the address wrap from a high reset PC.
  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst),
    .o_mem_req(d2_req), .o_mem_adr(d2_adr), .o_mem_load(d2_load),
    .o_mem_wdata(d2_wdata), .i_mem_rdata(d2_rdata), .i_mem_done(1'b1),
    .i_redirect(1'b0), .i_redirect_pc(32'h0),
    .o_if_valid(d2_valid), .o_if_instr(d2_instr), .o_if_pc(d2_pc),
    .i_if_ready(1'b1)
  );
  assign d2_rdata = word_of(d2_adr);

  // Memory responder: completes each request after lat wait cycles.
  initial begin
    mem_done  = 1'b0;
    mem_rdata = 32'h0;
  end
  always @(negedge clk) begin
    if (mem_req && !rst) begin
      if (!busy) begin
        busy = 1'b1;
        wcnt = lat_rand ? int'($urandom_range(0, 3)) : lat;
      end
      if (wcnt == 0) begin
        mem_done  = 1'b1;
        mem_rdata = word_of(mem_adr);
        busy      = 1'b0;
      end else begin
        mem_done  = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        wcnt--;
      end
    end else begin
      mem_done = 1'b0;
      busy     = 1'b0;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    lat = 0; lat_rand = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; if_ready = 1'b1;
    #2;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", mem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", if_instr); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", if_pc); end
    checks++; if (mem_load !== 1'b0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wr got %b/%h want 0/0", mem_load, mem_wdata); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b1 || mem_adr !== 32'h0) begin errors++; $display("FAIL reset_first_req got %b/%h want 1/00000000", mem_req, mem_adr); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] e;
    lat = 0; lat_rand = 1'b0;
    do_reset();
    if_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      e = 32'(4 * k);
      checks++; if (mem_req !== 1'b1 || mem_adr !== e) begin errors++; $display("FAIL zw_adr got %b/%h want 1/%h", mem_req, mem_adr, e); end
      if (k > 0) begin
        e = 32'(4 * (k - 1));
        checks++; if (if_valid !== 1'b1 || if_pc !== e || if_instr !== word_of(e)) begin
          errors++; $display("FAIL zw_out got %b/%h/%h want 1/%h/%h", if_valid, if_pc, if_instr, e, word_of(e)); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    lat = 0; lat_rand = 1'b0;
    do_reset();
    if_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      if (k >= 2) begin
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_req_full cyc %0d got %b want 0", k, mem_req); end
      end
      if (k == 4) begin
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL bp_head got %b/%h want 1/00000000", if_valid, if_pc); end
      end
    end
    exp_pc = 32'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if_ready = 1'b1;
      if (if_valid) begin
        checks++; if (if_pc !== exp_pc || if_instr !== word_of(exp_pc)) begin
          errors++; $display("FAIL bp_order got %h/%h want %h/%h", if_pc, if_instr, exp_pc, word_of(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
      end
    end
    checks++; if (exp_pc !== 32'd32) begin errors++; $display("FAIL bp_count got %h want 00000020", exp_pc); end
  endtask

  task automatic test_redirect_wait();
    bit found = 1'b0;
    bit got = 1'b0;
    int phase = 0;
    lat = 2; lat_rand = 1'b0;
    do_reset();
    if_ready = 1'b1;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk); #1;
      if (mem_req && mem_adr == 32'h8) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rw_find got none want req at 00000008"); end
    @(negedge clk); #1;
    checks++; if (mem_adr !== 32'h8 || mem_done !== 1'b0) begin errors++; $display("FAIL rw_wait2 got %h/%b want 00000008/0", mem_adr, mem_done); end
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk); #1;
      redirect = 1'b0;
      if (if_valid) begin
        checks++; if (if_pc !== 32'h100 || if_instr !== word_of(32'h100)) begin
          errors++; $display("FAIL rw_first_out got %h/%h want 00000100/%h", if_pc, if_instr, word_of(32'h100)); end
        got = 1'b1;
      end else if (phase == 0) begin
        checks++; if (mem_req !== 1'b1 || mem_adr !== 32'h8) begin errors++; $display("FAIL rw_hold got %b/%h want 1/00000008", mem_req, mem_adr); end
        if (mem_done) phase = 1;
      end else if (phase == 1 && mem_req) begin
        checks++; if (mem_adr !== 32'h100) begin errors++; $display("FAIL rw_newreq got %h want 00000100", mem_adr); end
        phase = 2;
      end
    end
    checks++; if (!got || phase != 2) begin errors++; $display("FAIL rw_timeout got phase %0d want 2", phase); end
  endtask

  task automatic test_redirect_done();
    lat = 0; lat_rand = 1'b0;
    do_reset();
    if_ready = 1'b1;
    repeat (3) begin @(negedge clk); #1; end
    @(negedge clk); #1;
    checks++; if (!(mem_req && mem_done && if_valid)) begin errors++; $display("FAIL rd_pre got %b%b%b want 111", mem_req, mem_done, if_valid); end
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    @(negedge clk); #1;
    redirect = 1'b0;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rd_flush got %b want 0", if_valid); end
    checks++; if (mem_req !== 1'b1 || mem_adr !== 32'h200) begin errors++; $display("FAIL rd_adr got %b/%h want 1/00000200", mem_req, mem_adr); end
    @(negedge clk); #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200) begin errors++; $display("FAIL rd_out got %b/%h want 1/00000200", if_valid, if_pc); end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    lat = 3; lat_rand = 1'b0;
    do_reset();
    if_ready = 1'b0;
    @(negedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h0000_003C;
    for (int n = 0; n < 30 && !found; n++) begin
      @(negedge clk); #1;
      redirect = 1'b0;
      if (mem_req && mem_adr == 32'h40 && !mem_done) found = 1'b1;
    end
    checks++; if (!found || if_valid !== 1'b1) begin errors++; $display("FAIL rm_pre got found %b valid %b want 1/1", found, if_valid); end
    rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL rm_drop got %b/%b want 0/0", mem_req, if_valid); end
    repeat (2) @(posedge clk);
    lat = 0;
    #1 rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b1 || mem_adr !== 32'h0 || if_valid !== 1'b0) begin
      errors++; $display("FAIL rm_restart got %b/%h/%b want 1/00000000/0", mem_req, mem_adr, if_valid); end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      e = 32'hFFFF_FFF8 + 32'(4 * k);
      checks++; if (d2_req !== 1'b1 || d2_adr !== e) begin errors++; $display("FAIL wrap_adr got %b/%h want 1/%h", d2_req, d2_adr, e); end
      if (k > 0) begin
        e = e - 32'd4;
        checks++; if (d2_valid !== 1'b1 || d2_pc !== e || d2_instr !== word_of(e)) begin
          errors++; $display("FAIL wrap_out got %b/%h/%h want 1/%h/%h", d2_valid, d2_pc, d2_instr, e, word_of(e)); end
      end
    end
  endtask

  // Reference: decode sees a contiguous PC stream restarting at each redirect target.
  task automatic test_random();
    logic [31:0] exp_pc, padr, tgt, a;
    bit pend, prev_redir, rdy, redir;
    int n_del;
    lat_rand = 1'b1;
    do_reset();
    exp_pc = 32'h0; pend = 1'b0; prev_redir = 1'b0; padr = 32'h0; n_del = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk); #1;
      a = mem_adr;
      if (prev_redir) begin
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rnd_flush cyc %0d got %b want 0", n, if_valid); end
      end
      if (pend) begin
        checks++; if (mem_req !== 1'b1 || mem_adr !== padr) begin errors++; $display("FAIL rnd_stable cyc %0d got %b/%h want 1/%h", n, mem_req, mem_adr, padr); end
      end
      checks++; if (a[1:0] !== 2'b00 || mem_load !== 1'b0 || mem_wdata !== 32'h0) begin
        errors++; $display("FAIL rnd_bus cyc %0d got %h/%b/%h want aligned/0/0", n, a, mem_load, mem_wdata); end
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 24) == 0);
      tgt   = $urandom;
      if_ready = rdy; redirect = redir; redirect_pc = tgt;
      if (if_valid && rdy && !redir) begin
        checks++; if (if_pc !== exp_pc || if_instr !== word_of(exp_pc)) begin
          errors++; $display("FAIL rnd_out cyc %0d got %h/%h want %h/%h", n, if_pc, if_instr, exp_pc, word_of(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        n_del++;
      end
      if (redir) exp_pc = {tgt[31:2], 2'b00};
      prev_redir = redir;
      pend = mem_req && !mem_done;
      padr = mem_adr;
    end
    redirect = 1'b0;
    lat_rand = 1'b0;
    checks++; if (n_del < 50) begin errors++; $display("FAIL rnd_progress got %0d want >=50", n_del); end
  endtask

  initial begin
    redirect = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_redirect_wait();
    test_redirect_done();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Initiator side of the instruction-memory interface.
- Owns the fetch PC and issues word-aligned read requests to the instruction memory, one outstanding at a time.
- Buffers returned words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects from execute: flushes the FIFO and discards any stale in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- FIFO_DEPTH, 2, number of {pc, instr} entries buffered toward decode (power of two, ≥2).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  out  1  read request to instruction memory (level).
- mem_adr  out  32  byte address of request; bits [1:0] always 0.
- mem_load  out  1  write enable toward memory; constant 0.
- mem_wdata  out  32  write data toward memory; constant 0.
- mem_rdata  in  32  read word; valid only in a cycle with mem_done=1 and mem_req=1.
- mem_done  in  1  completion; when high with mem_req=1, the transaction completes this cycle.
- redirect  in  1  single-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced to 0).
- if_valid  out  1  FIFO head valid toward decode.
- if_instr  out  32  instruction at FIFO head.
- if_pc  out  32  PC of instruction at FIFO head.
- if_ready  in  1  decode accepts head this cycle.

Behaviour:
- Reset (async, while rst=1):
  - fetch_pc = RESET_PC with bits [1:0] forced to 0.
  - FIFO count = 0; all entries = 0.
  - state = FETCH.
  - if_valid = 0; if_instr = 0; if_pc = 0; mem_req = 0.
- States:
  - FETCH: mem_req = (count < FIFO_DEPTH); mem_adr = fetch_pc.
  - DROP: mem_req = 1; mem_adr = stale_pc. Only waits for the abandoned transaction to complete; its data is discarded.
- Request rule:
  - mem_req and mem_adr stay stable from assertion until a cycle with mem_done=1.
  - Zero-wait memory (mem_done=1 in the request cycle) gives one word per cycle.
- Completion in FETCH, no redirect:
  - push {fetch_pc, mem_rdata} into FIFO.
  - fetch_pc = fetch_pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Pop:
  - if_valid = (count != 0); head entry is driven combinationally from FIFO storage.
  - Entry is removed when if_valid && if_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Push cannot occur at count == FIFO_DEPTH because mem_req is low then.
- Redirect (priority over push/pop):
  - FIFO count = 0 (if_valid low next cycle); any pop that cycle is ignored.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - If mem_req=1 and mem_done=0 that cycle: stale_pc = current mem_adr; state = DROP.
  - If mem_done=1 that cycle: data discarded; state = FETCH; new address requested next cycle.
  - If mem_req=0: state = FETCH.
- DROP:
  - On mem_done=1: discard data; state = FETCH.
  - A further redirect while in DROP only updates fetch_pc; state stays DROP.
- Reset asserted mid-transaction abandons it immediately; no completion is expected after reset release.
- mem_load and mem_wdata never change. This block never writes memory.

Test Plan:
- Reset, zero-wait memory returning word = address XOR 32'hA5A5_0000, if_ready=1 always → mem_adr 0,4,8,… on consecutive cycles; if_pc/if_instr (0,A5A5_0000), (4,A5A5_0004), … one per cycle, no gaps after first.
- if_ready=0 for 5 cycles after reset → exactly 2 words buffered (pc 0,4); mem_req low while full; on if_ready=1, pc 0,4,8 delivered in order with no loss or duplicate.
- Memory with 3-cycle latency; redirect to 32'h0000_0103 in the second wait cycle of request at 8 → mem_adr holds 8 until done; word for 8 never appears; next request and first delivered if_pc = 32'h100.
- Redirect in same cycle as mem_done and if_valid&&if_ready → FIFO emptied; returned word dropped; next cycle mem_adr = redirect target.
- RESET_PC=32'hFFFF_FFF8, zero-wait memory → requests FFFF_FFF8, FFFF_FFFC, 0000_0000 in sequence.
- rst asserted while request to 32'h40 pending → mem_req and if_valid drop immediately; after release, first request is to RESET_PC.
